// File: rtl/data_mem_mmio_if.sv
// CPU data-port bundle for data_mem_mmio: request/response signals plus the I/O port buses.
// The master side drives requests and io_in. The slave side drives read data and the io_out ports.
interface data_mem_mmio_if #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int IO_PORTS = 4
);
    logic [ADDR_W-1:0]          addr;
    logic [DATA_W-1:0]          wdata;
    logic                       we;
    logic                       re;
    logic [DATA_W-1:0]          rdata;
    logic                       rvalid;
    logic [IO_PORTS*DATA_W-1:0] io_out;
    logic [IO_PORTS-1:0]        io_out_stb;
    logic [IO_PORTS*DATA_W-1:0] io_in;

    modport master (
        output addr, wdata, we, re, io_in,
        input  rdata, rvalid, io_out, io_out_stb
    );

    modport slave (
        input  addr, wdata, we, re, io_in,
        output rdata, rvalid, io_out, io_out_stb
    );
endinterface

// File: rtl/data_mem_mmio.sv
// Data memory with a low-address I/O window: word indices below IO_PORTS hit output/input
// port registers, and every other index hits an aliased single-port RAM. Reads return after one cycle.
module data_mem_mmio #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 512,
    parameter int IO_PORTS = 4
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_mmio_if.slave     bus
);
    localparam int RAM_AW = $clog2(DEPTH);

    logic [ADDR_W-2:0]          wi_s;
    logic [RAM_AW-1:0]          ram_idx_s;
    logic [2:0]                 port_s;
    logic                       is_io_s;
    logic                       unused_addr_lsb_s;
    logic [IO_PORTS-1:0]        io_wr_s;
    logic [DATA_W-1:0]          rd_io_s;
    logic [DATA_W-1:0]          rd_ram_s;
    logic [DATA_W-1:0]          rd_next_s;

    logic [DATA_W-1:0]          ram_r [DEPTH];
    logic [DATA_W-1:0]          rdata_r;
    logic                       rvalid_r;
    logic [IO_PORTS*DATA_W-1:0] io_out_r;
    logic [IO_PORTS-1:0]        io_stb_r;
    logic [IO_PORTS*DATA_W-1:0] sync1_r;
    logic [IO_PORTS*DATA_W-1:0] sync2_r;

    assign wi_s              = bus.addr[ADDR_W-1:1];
    assign unused_addr_lsb_s = bus.addr[0];
    assign ram_idx_s         = wi_s[RAM_AW-1:0];
    assign port_s            = wi_s[2:0];
    assign rd_ram_s          = ram_r[ram_idx_s];

    // Address decode: I/O window select and one-hot port write enables.
    always_comb begin
        is_io_s = 1'b0;
        io_wr_s = '0;
        if (wi_s < (ADDR_W-1)'(IO_PORTS)) begin
            is_io_s = 1'b1;
        end else begin
            is_io_s = 1'b0;
        end
        for (int k = 0; k < IO_PORTS; k++) begin
            io_wr_s[k] = bus.we && is_io_s && (port_s == 3'(k));
        end
    end

    // Read data mux: synchronised input port or RAM word (RAM read happens before any write this edge).
    always_comb begin
        rd_io_s   = '0;
        rd_next_s = '0;
        for (int k = 0; k < IO_PORTS; k++) begin
            rd_io_s = rd_io_s | ((port_s == 3'(k)) ? sync2_r[k*DATA_W +: DATA_W] : {DATA_W{1'b0}});
        end
        if (is_io_s) begin
            rd_next_s = rd_io_s;
        end else begin
            rd_next_s = rd_ram_s;
        end
    end

    // RAM write port; contents survive reset, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && bus.we && !is_io_s) begin
            ram_r[ram_idx_s] <= bus.wdata;
        end
    end

    // Read response, output ports, write strobes and the two-flop input synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
            io_out_r <= '0;
            io_stb_r <= '0;
            sync1_r  <= '0;
            sync2_r  <= '0;
        end else begin
            sync1_r  <= bus.io_in;
            sync2_r  <= sync1_r;
            rvalid_r <= bus.re;
            if (bus.re) begin
                rdata_r <= rd_next_s;
            end
            io_stb_r <= io_wr_s;
            for (int k = 0; k < IO_PORTS; k++) begin
                if (io_wr_s[k]) begin
                    io_out_r[k*DATA_W +: DATA_W] <= bus.wdata;
                end
            end
        end
    end

    assign bus.rdata      = rdata_r;
    assign bus.rvalid     = rvalid_r;
    assign bus.io_out     = io_out_r;
    assign bus.io_out_stb = io_stb_r;
endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: a vector table for single-cycle behaviour plus
// hand-written sequences for strobes, input synchronisation and reset interaction.
module tb_data_mem_mmio;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    data_mem_mmio_if #(.DATA_W(16), .ADDR_W(16), .IO_PORTS(4)) bus ();

    data_mem_mmio #(.DATA_W(16), .ADDR_W(16), .DEPTH(512), .IO_PORTS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        chk_rd;
        logic [15:0] exp_rdata;
        logic        exp_rvalid;
        logic [3:0]  exp_stb;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        bus.we = 1'b0; bus.re = 1'b0; bus.addr = 16'h0000; bus.wdata = 16'h0000;
        bus.io_in = 64'h0;

        //                we    re    addr      wdata     chk   rdata     rv    stb
        vecs[0]  = '{1'b1, 1'b0, 16'h0100, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 4'b0000};
        vecs[1]  = '{1'b1, 1'b1, 16'h0100, 16'h5A5A, 1'b1, 16'hA5A5, 1'b1, 4'b0000};
        vecs[2]  = '{1'b0, 1'b1, 16'h0100, 16'h0000, 1'b1, 16'h5A5A, 1'b1, 4'b0000};
        vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0011, 1'b1, 16'h5A5A, 1'b0, 4'b0000};
        vecs[4]  = '{1'b0, 1'b1, 16'h0410, 16'h0000, 1'b1, 16'h0011, 1'b1, 4'b0000};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b0, 4'b0001};
        vecs[6]  = '{1'b1, 1'b0, 16'h0006, 16'h7777, 1'b0, 16'h0000, 1'b0, 4'b1000};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0011, 1'b0, 4'b0000};
        vecs[8]  = '{1'b1, 1'b0, 16'h0008, 16'hCAFE, 1'b0, 16'h0000, 1'b0, 4'b0000};
        vecs[9]  = '{1'b0, 1'b1, 16'h0408, 16'h0000, 1'b1, 16'hCAFE, 1'b1, 4'b0000};
        vecs[10] = '{1'b0, 1'b1, 16'h0002, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b0000};
        vecs[11] = '{1'b1, 1'b1, 16'h0002, 16'h1111, 1'b1, 16'h0000, 1'b1, 4'b0010};

        // reset state
        tick();
        tick();
        check("rst_rdata",  64'(bus.rdata),      64'h0);
        check("rst_rvalid", 64'(bus.rvalid),     64'h0);
        check("rst_io_out", bus.io_out,          64'h0);
        check("rst_stb",    64'(bus.io_out_stb), 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus.we    = vecs[i].we;
            bus.re    = vecs[i].re;
            bus.addr  = vecs[i].addr;
            bus.wdata = vecs[i].wdata;
            tick();
            check($sformatf("vec%0d_rvalid", i), 64'(bus.rvalid), 64'(vecs[i].exp_rvalid));
            check($sformatf("vec%0d_stb", i), 64'(bus.io_out_stb), 64'(vecs[i].exp_stb));
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d_rdata", i), 64'(bus.rdata), 64'(vecs[i].exp_rdata));
            end
        end
        bus.we = 1'b0; bus.re = 1'b0;
        check("table_io_out", bus.io_out, 64'h7777_0000_1111_0001);

        // single port write: strobe for one cycle, other ports untouched
        bus.we = 1'b1; bus.addr = 16'h0004; bus.wdata = 16'hBEEF;
        tick();
        bus.we = 1'b0;
        check("p2_stb",    64'(bus.io_out_stb), 64'h4);
        check("p2_io_out", bus.io_out,          64'h7777_BEEF_1111_0001);
        tick();
        check("p2_stb_clear", 64'(bus.io_out_stb), 64'h0);

        // back-to-back writes to one port strobe every cycle
        bus.we = 1'b1; bus.addr = 16'h0004; bus.wdata = 16'h0102;
        tick();
        check("b2b_stb0", 64'(bus.io_out_stb), 64'h4);
        bus.wdata = 16'h0304;
        tick();
        bus.we = 1'b0;
        check("b2b_stb1", 64'(bus.io_out_stb), 64'h4);
        check("b2b_io_out", bus.io_out, 64'h7777_0304_1111_0001);

        // input synchroniser: change before edge 0, visible from the read at edge 2
        bus.io_in = 64'h0000_0000_1234_0000;
        tick();
        bus.re = 1'b1; bus.addr = 16'h0002;
        tick();
        check("sync_e1_rvalid", 64'(bus.rvalid), 64'h1);
        check("sync_e1_rdata",  64'(bus.rdata),  64'h0);
        tick();
        check("sync_e2_rdata",  64'(bus.rdata),  64'h1234);
        tick();
        check("sync_e3_rvalid", 64'(bus.rvalid), 64'h1);
        check("sync_e3_rdata",  64'(bus.rdata),  64'h1234);
        bus.re = 1'b0;
        tick();
        check("sync_rvalid_drop", 64'(bus.rvalid), 64'h0);
        check("sync_rdata_hold",  64'(bus.rdata),  64'h1234);

        // reset right after an accepted read; reset dominates writes; RAM survives
        bus.we = 1'b1; bus.addr = 16'h0200; bus.wdata = 16'h3C3C;
        tick();
        bus.we = 1'b0; bus.re = 1'b1;
        tick();
        check("pre_rst_rvalid", 64'(bus.rvalid), 64'h1);
        check("pre_rst_rdata",  64'(bus.rdata),  64'h3C3C);
        bus.re = 1'b0; rst = 1'b1;
        tick();
        check("mid_rst_rvalid", 64'(bus.rvalid), 64'h0);
        check("mid_rst_rdata",  64'(bus.rdata),  64'h0);
        check("mid_rst_io_out", bus.io_out,      64'h0);
        bus.we = 1'b1; bus.addr = 16'h0200; bus.wdata = 16'hDEAD;
        tick();
        bus.addr = 16'h0000; bus.wdata = 16'hFFFF; bus.re = 1'b1;
        tick();
        check("rst_we_stb",    64'(bus.io_out_stb), 64'h0);
        check("rst_we_io_out", bus.io_out,          64'h0);
        check("rst_re_rvalid", 64'(bus.rvalid),     64'h0);
        rst = 1'b0; bus.we = 1'b0; bus.re = 1'b1; bus.addr = 16'h0200;
        tick();
        bus.re = 1'b0;
        check("post_rst_rvalid", 64'(bus.rvalid), 64'h1);
        check("post_rst_ram",    64'(bus.rdata),  64'h3C3C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
